// File: rtl/jpeg_outport_buffer_if.sv
// jpeg_outport_buffer_if
// Bundles the pixel-side handshake, the consumer-side handshake and the
// status outputs of the JPEG output-port buffer.
//   slave  modport : the buffer itself
//   master modport : whatever drives pixels in and consumes entries out
// Signal names keep the buffer's point of view (_i = into the buffer,
// _o = out of the buffer) so the two modports read unambiguously.
//   in_valid_i / in_accept_o         : pixel handshake
//   in_width_i, in_height_i          : frame geometry
//   in_x_i, in_y_i, in_pix_i         : pixel coordinate and channels (ch0 in LSBs)
//   drop_mode_i                      : 0 = backpressure, 1 = accept and discard when full
//   out_v_o / out_data_o / out_yumi_i: head entry and consumer take
//   level_o, drop_cnt_o              : occupancy and saturating drop count
//   frame_done_o, frame_err_o        : frame completion pulse, sticky count error
interface jpeg_outport_buffer_if #(
   parameter int DIM_W_P  = 16,
   parameter int CHAN_P   = 3,
   parameter int CHAN_W_P = 8,
   parameter int DEPTH_P  = 4
);
   localparam int DATA_W = 4*DIM_W_P + CHAN_P*CHAN_W_P;
   localparam int LVL_W  = $clog2(DEPTH_P) + 1;

   logic                       in_valid_i;
   logic [DIM_W_P-1:0]         in_width_i;
   logic [DIM_W_P-1:0]         in_height_i;
   logic [DIM_W_P-1:0]         in_x_i;
   logic [DIM_W_P-1:0]         in_y_i;
   logic [CHAN_P*CHAN_W_P-1:0] in_pix_i;
   logic                       in_accept_o;
   logic                       drop_mode_i;
   logic                       out_v_o;
   logic [DATA_W-1:0]          out_data_o;
   logic                       out_yumi_i;
   logic [LVL_W-1:0]           level_o;
   logic [15:0]                drop_cnt_o;
   logic                       frame_done_o;
   logic                       frame_err_o;

   modport slave (
      input  in_valid_i, in_width_i, in_height_i, in_x_i, in_y_i, in_pix_i,
      input  drop_mode_i, out_yumi_i,
      output in_accept_o, out_v_o, out_data_o, level_o, drop_cnt_o,
      output frame_done_o, frame_err_o
   );

   modport master (
      output in_valid_i, in_width_i, in_height_i, in_x_i, in_y_i, in_pix_i,
      output drop_mode_i, out_yumi_i,
      input  in_accept_o, out_v_o, out_data_o, level_o, drop_cnt_o,
      input  frame_done_o, frame_err_o
   );
endinterface

// File: rtl/jpeg_outport_buffer.sv
// jpeg_outport_buffer
// Small FIFO between a pixel-producing JPEG core and an output consumer.
// Entries are packed {width,height,x,y,pix} with width in the MSBs.
// In backpressure mode the core is stalled when the FIFO is full; in drop
// mode every beat is accepted and beats arriving at full are discarded and
// counted. Every accepted beat (stored or dropped) advances a frame pixel
// counter that is checked against width*height on the last pixel.
// Ports:
//   clk_i : rising-edge clock
//   rst_i : synchronous active-high reset
//   bus   : jpeg_outport_buffer_if.slave (all handshake, data and status)
module jpeg_outport_buffer #(
   parameter int DIM_W_P  = 16,
   parameter int CHAN_P   = 3,
   parameter int CHAN_W_P = 8,
   parameter int DEPTH_P  = 4
) (
   input logic                  clk_i,
   input logic                  rst_i,
   jpeg_outport_buffer_if.slave bus
);
   localparam int DATA_W = 4*DIM_W_P + CHAN_P*CHAN_W_P;
   localparam int PTR_W  = $clog2(DEPTH_P);
   localparam int LVL_W  = PTR_W + 1;
   localparam int CNT_W  = 2*DIM_W_P;

   logic [DATA_W-1:0] mem_q [DEPTH_P];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;

   logic              full_s, empty_s, accept_s;
   logic              in_beat_s, wr_en_s, rd_en_s, drop_s, last_pix_s;
   logic [CNT_W-1:0]  frame_size_s, pix_cnt_inc_s;
   logic [DATA_W-1:0] wr_data_s;

   // Handshake decode. Fullness is taken from the registered level, so a read
   // in the same cycle never frees room for a write.
   always_comb begin
      full_s   = (level_q == LVL_W'(DEPTH_P));
      empty_s  = (level_q == {LVL_W{1'b0}});
      if (rst_i) begin
         accept_s = 1'b0;
      end else if (bus.drop_mode_i) begin
         accept_s = 1'b1;
      end else begin
         accept_s = ~full_s;
      end
      in_beat_s = bus.in_valid_i & accept_s;
      wr_en_s   = in_beat_s & ~full_s;
      drop_s    = in_beat_s & full_s;
      rd_en_s   = bus.out_yumi_i & ~empty_s;
      wr_data_s = {bus.in_width_i, bus.in_height_i, bus.in_x_i, bus.in_y_i, bus.in_pix_i};
      // A zero dimension never matches, so such frames never complete.
      last_pix_s = (bus.in_width_i != {DIM_W_P{1'b0}}) &&
                   (bus.in_height_i != {DIM_W_P{1'b0}}) &&
                   (bus.in_x_i == bus.in_width_i - DIM_W_P'(1)) &&
                   (bus.in_y_i == bus.in_height_i - DIM_W_P'(1));
      frame_size_s  = CNT_W'(bus.in_width_i) * CNT_W'(bus.in_height_i);
      pix_cnt_inc_s = pix_cnt_q + CNT_W'(1);
   end

   // Next-state for pointers, level, drop counter and frame tracking.
   always_comb begin
      if (wr_en_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
      frame_done_d = 1'b0;
      frame_err_d  = frame_err_q;
      pix_cnt_d    = pix_cnt_q;
      if (in_beat_s) begin
         if (last_pix_s) begin
            frame_done_d = 1'b1;
            frame_err_d  = frame_err_q | (pix_cnt_inc_s != frame_size_s);
            pix_cnt_d    = {CNT_W{1'b0}};
         end else begin
            pix_cnt_d    = pix_cnt_inc_s;
         end
      end else begin
         pix_cnt_d = pix_cnt_q;
      end
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         level_q      <= {LVL_W{1'b0}};
         drop_cnt_q   <= 16'd0;
         pix_cnt_q    <= {CNT_W{1'b0}};
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         drop_cnt_q   <= drop_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Entry storage; left unreset because the output is masked while empty.
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= wr_data_s;
      end
   end

   // Output drive; head data reads as zero whenever nothing is held.
   always_comb begin
      bus.in_accept_o  = accept_s;
      bus.out_v_o      = ~empty_s;
      bus.level_o      = level_q;
      bus.drop_cnt_o   = drop_cnt_q;
      bus.frame_done_o = frame_done_q;
      bus.frame_err_o  = frame_err_q;
      if (empty_s) begin
         bus.out_data_o = {DATA_W{1'b0}};
      end else begin
         bus.out_data_o = mem_q[rd_ptr_q];
      end
   end

   // A take from an empty buffer is harmless to the datapath but indicates a
   // broken consumer.
   yumi_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
                                     !(bus.out_yumi_i && empty_s));
endmodule

// File: tb/tb_jpeg_outport_buffer.sv
// Directed bench for jpeg_outport_buffer at default parameters.
module tb_jpeg_outport_buffer;
   localparam int DATA_W = 88;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic yumi_en = 1'b0;
   logic rand_yumi = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int max_level = 0;
   logic [DATA_W-1:0] recv[$];
   logic [DATA_W-1:0] exp_q[$];

   jpeg_outport_buffer_if #(.DIM_W_P(16), .CHAN_P(3), .CHAN_W_P(8), .DEPTH_P(4)) bus();

   jpeg_outport_buffer #(.DIM_W_P(16), .CHAN_P(3), .CHAN_W_P(8), .DEPTH_P(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // consumer only ever takes a valid head
   assign bus.out_yumi_i = yumi_en & bus.out_v_o;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_v_o && bus.out_yumi_i) recv.push_back(bus.out_data_o);
         if (bus.frame_done_o) done_cnt++;
         if (int'(bus.level_o) > max_level) max_level = int'(bus.level_o);
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_yumi) yumi_en = 1'($urandom_range(0, 1));
   end

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [23:0] pix_of(input logic [15:0] x, input logic [15:0] y);
      logic [7:0] s;
      s = x[7:0] + y[7:0];
      return {x[3:0], y[3:0], 8'hA5, s};
   endfunction

   function automatic logic [DATA_W-1:0] pack(input logic [15:0] w, h, x, y);
      return {w, h, x, y, pix_of(x, y)};
   endfunction

   task automatic set_beat(input logic [15:0] w, h, x, y);
      bus.in_width_i  = w;
      bus.in_height_i = h;
      bus.in_x_i      = x;
      bus.in_y_i      = y;
      bus.in_pix_i    = pix_of(x, y);
      bus.in_valid_i  = 1'b1;
   endtask

   // Called and returns at #1 after a rising edge.
   task automatic send(input logic [15:0] w, h, x, y);
      bit ok;
      int n;
      set_beat(w, h, x, y);
      ok = 1'b0;
      n = 0;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = bus.in_accept_o;
         @(posedge clk); #1;
         n++;
      end
      bus.in_valid_i = 1'b0;
      check_eq("send_accept", ok, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      check_eq("accept_in_reset", bus.in_accept_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      recv.delete();
      exp_q.delete();
      done_cnt = 0;
      max_level = 0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_recv(input int n);
      for (int i = 0; i < 300 && recv.size() < n; i++) @(posedge clk);
      #1;
      check_eq("recv_count", recv.size(), n);
   endtask

   task automatic cmp_recv(input string tag);
      for (int i = 0; i < exp_q.size() && i < recv.size(); i++)
         check_eq(tag, recv[i], exp_q[i]);
   endtask

   initial begin
      logic [DATA_W-1:0] d31;
      bus.in_valid_i = 1'b0;
      bus.in_width_i = 16'd0;
      bus.in_height_i = 16'd0;
      bus.in_x_i = 16'd0;
      bus.in_y_i = 16'd0;
      bus.in_pix_i = 24'd0;
      bus.drop_mode_i = 1'b0;

      // reset state
      @(posedge clk); #1;
      do_reset();
      @(negedge clk);
      check_eq("rst_out_v", bus.out_v_o, 0);
      check_eq("rst_level", bus.level_o, 0);
      check_eq("rst_drop", bus.drop_cnt_o, 0);
      check_eq("rst_done", bus.frame_done_o, 0);
      check_eq("rst_err", bus.frame_err_o, 0);
      check_eq("rst_data", bus.out_data_o, 0);
      @(posedge clk); #1;

      // basic 4x2 flow
      yumi_en = 1'b1;
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++) begin
            send(16'd4, 16'd2, 16'(x), 16'(y));
            exp_q.push_back(pack(16'd4, 16'd2, 16'(x), 16'(y)));
         end
      wait_recv(8);
      cmp_recv("basic_order");
      d31 = 88'h0004_0002_0003_0001_31A504;
      if (recv.size() == 8) check_eq("basic_px31", recv[7], d31);
      wait_cycles(3);
      check_eq("basic_done", done_cnt, 1);
      check_eq("basic_err", bus.frame_err_o, 0);

      // backpressure, plus no fall-through on the first write
      do_reset();
      yumi_en = 1'b0;
      set_beat(16'd100, 16'd100, 16'd0, 16'd0);
      exp_q.push_back(pack(16'd100, 16'd100, 16'd0, 16'd0));
      @(negedge clk);
      check_eq("no_fallthru", bus.out_v_o, 0);
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      check_eq("first_v", bus.out_v_o, 1);
      check_eq("first_data", bus.out_data_o, exp_q[0]);
      @(posedge clk); #1;
      for (int x = 1; x < 4; x++) begin
         send(16'd100, 16'd100, 16'(x), 16'd0);
         exp_q.push_back(pack(16'd100, 16'd100, 16'(x), 16'd0));
      end
      @(negedge clk);
      check_eq("bp_level", bus.level_o, 4);
      check_eq("bp_accept", bus.in_accept_o, 0);
      check_eq("bp_head_hold", bus.out_data_o, exp_q[0]);
      @(posedge clk); #1;
      yumi_en = 1'b1;
      for (int x = 4; x < 6; x++) begin
         send(16'd100, 16'd100, 16'(x), 16'd0);
         exp_q.push_back(pack(16'd100, 16'd100, 16'(x), 16'd0));
      end
      wait_recv(6);
      cmp_recv("bp_order");
      wait_cycles(2);
      check_eq("bp_empty", bus.level_o, 0);

      // drop mode at full, then concurrent take + write at full
      do_reset();
      yumi_en = 1'b0;
      for (int x = 0; x < 4; x++) begin
         send(16'd100, 16'd100, 16'(x), 16'd0);
         exp_q.push_back(pack(16'd100, 16'd100, 16'(x), 16'd0));
      end
      bus.drop_mode_i = 1'b1;
      for (int x = 10; x < 13; x++) send(16'd100, 16'd100, 16'(x), 16'd0);
      @(negedge clk);
      check_eq("drop_cnt3", bus.drop_cnt_o, 3);
      check_eq("drop_level", bus.level_o, 4);
      check_eq("drop_accept", bus.in_accept_o, 1);
      check_eq("drop_head", bus.out_data_o, exp_q[0]);
      @(posedge clk); #1;
      yumi_en = 1'b1;
      set_beat(16'd100, 16'd100, 16'd13, 16'd0);
      @(posedge clk); #1;
      yumi_en = 1'b0;
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      check_eq("rw_full_level", bus.level_o, 3);
      check_eq("rw_full_drop", bus.drop_cnt_o, 4);
      @(posedge clk); #1;
      bus.drop_mode_i = 1'b0;
      yumi_en = 1'b1;
      wait_recv(4);
      cmp_recv("drop_data");

      // frame mismatch, sticky error
      do_reset();
      yumi_en = 1'b1;
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++)
            if (!(x == 1 && y == 0)) send(16'd4, 16'd2, 16'(x), 16'(y));
      wait_cycles(3);
      check_eq("mis_done", done_cnt, 1);
      check_eq("mis_err", bus.frame_err_o, 1);
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++) send(16'd4, 16'd2, 16'(x), 16'(y));
      wait_cycles(3);
      check_eq("mis_done2", done_cnt, 2);
      check_eq("mis_err_sticky", bus.frame_err_o, 1);

      // reset mid-operation: level 3, frame count 5, one drop
      do_reset();
      yumi_en = 1'b0;
      bus.drop_mode_i = 1'b1;
      for (int x = 0; x < 4; x++) send(16'd4, 16'd2, 16'(x), 16'd0);
      yumi_en = 1'b1;
      set_beat(16'd4, 16'd2, 16'd0, 16'd1);
      @(posedge clk); #1;
      yumi_en = 1'b0;
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      check_eq("mid_level", bus.level_o, 3);
      check_eq("mid_drop", bus.drop_cnt_o, 1);
      @(posedge clk); #1;
      bus.drop_mode_i = 1'b0;
      do_reset();
      @(negedge clk);
      check_eq("mid_rst_v", bus.out_v_o, 0);
      check_eq("mid_rst_level", bus.level_o, 0);
      check_eq("mid_rst_drop", bus.drop_cnt_o, 0);
      check_eq("mid_rst_done", bus.frame_done_o, 0);
      @(posedge clk); #1;
      yumi_en = 1'b1;
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++) send(16'd4, 16'd2, 16'(x), 16'(y));
      wait_recv(8);
      wait_cycles(3);
      check_eq("mid_done", done_cnt, 1);
      check_eq("mid_err", bus.frame_err_o, 0);

      // zero-dimension frame never completes; then wrap with random take
      do_reset();
      yumi_en = 1'b1;
      send(16'd0, 16'd0, 16'hFFFF, 16'hFFFF);
      wait_cycles(3);
      check_eq("zero_dim_done", done_cnt, 0);
      recv.delete();
      max_level = 0;
      rand_yumi = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send(16'd100, 16'd100, 16'(i * 3), 16'(i));
         exp_q.push_back(pack(16'd100, 16'd100, 16'(i * 3), 16'(i)));
      end
      rand_yumi = 1'b0;
      yumi_en = 1'b1;
      wait_recv(20);
      cmp_recv("wrap_order");
      check_eq("wrap_max_level", (max_level <= 4), 1);
      check_eq("wrap_end_level", bus.level_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/jpeg_outport_buffer.md
JPEG_OUTPORT_BUFFER -- requirements
Module: jpeg_outport_buffer

Interface
REQ-001 The block SHALL have parameter DIM_W_P, default 16, giving the width, height and coordinate field width.
REQ-002 The block SHALL have parameter CHAN_P, default 3, giving the number of pixel channels.
REQ-003 The block SHALL have parameter CHAN_W_P, default 8, giving bits per channel.
REQ-004 The block SHALL have parameter DEPTH_P, default 4, giving FIFO entries; it is a power of 2 and at least 2.
REQ-005 The block SHALL derive DATA_W = 4*DIM_W_P + CHAN_P*CHAN_W_P, which is 88 at defaults.
REQ-006 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  core pixel valid.
- in_width_i  in  DIM_W_P  image width.
- in_height_i  in  DIM_W_P  image height.
- in_x_i  in  DIM_W_P  pixel x.
- in_y_i  in  DIM_W_P  pixel y.
- in_pix_i  in  CHAN_P*CHAN_W_P  channels, channel 0 in the LSBs.
- in_accept_o  out  1  core-side accept.
- drop_mode_i  in  1  0 = backpressure, 1 = accept always and discard when full.
- out_v_o  out  1  head entry valid.
- out_data_o  out  DATA_W  packed {width,height,x,y,pix}, width in the MSBs.
- out_yumi_i  in  1  consumer takes head this cycle; legal only while out_v_o=1.
- level_o  out  clog2(DEPTH_P)+1  entries held.
- drop_cnt_o  out  16  saturating count of discarded beats.
- frame_done_o  out  1  one-cycle pulse per completed frame.
- frame_err_o  out  1  sticky pixel-count mismatch flag.

Function
REQ-007 An input beat SHALL be defined as in_valid_i & in_accept_o; an output beat SHALL be defined as out_v_o & out_yumi_i.
REQ-008 in_accept_o SHALL equal ~full when drop_mode_i=0 and 1 when drop_mode_i=1, and SHALL have no combinational path from out_yumi_i.
REQ-009 An input beat with the FIFO not full SHALL write one entry.
REQ-010 An input beat with the FIFO full (drop_mode_i=1 only) SHALL write nothing and SHALL increment drop_cnt_o, saturating at 16'hFFFF.
REQ-011 A written entry SHALL appear on out_v_o/out_data_o the cycle after the write; there is no fall-through path.
REQ-012 out_v_o SHALL equal ~empty, and out_data_o SHALL be the head entry, held stable while out_v_o=1 and out_yumi_i=0.
REQ-013 A simultaneous write and read SHALL leave level_o unchanged, and SHALL be legal at full when drop_mode_i=1 (the write is dropped, because fullness is evaluated before the read) and at any non-full level.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH_P; the full/empty distinction SHALL come from level_o or an extra pointer bit.
REQ-015 out_yumi_i asserted while empty SHALL be ignored, with no state change, and SHALL be flagged by a simulation assertion.
REQ-016 A frame pixel counter SHALL count input beats, including dropped beats, in 2*DIM_W_P bits.
REQ-017 On an input beat with in_x_i = in_width_i-1 and in_y_i = in_height_i-1 (last pixel), the block SHALL:
- pulse frame_done_o for exactly one cycle, the cycle after the beat;
- set frame_err_o if counter+1 != in_width_i*in_height_i (full 2*DIM_W_P-bit product);
- clear the frame pixel counter to 0.
REQ-018 frame_err_o SHALL stay set until reset.
REQ-019 in_width_i=0 or in_height_i=0 SHALL never produce a frame_done_o pulse.
REQ-020 A drop_mode_i change SHALL take effect in the same cycle; entries already stored SHALL be unaffected.

Reset
REQ-021 While rst_i=1 at a rising clk_i edge, the block SHALL:
- empty the FIFO and zero the pointers;
- set level_o=0, drop_cnt_o=0, frame_done_o=0, frame_err_o=0 and clear the frame pixel counter;
- drive out_v_o=0 and out_data_o=0 from the next cycle.
REQ-022 During reset, in_accept_o SHALL be 0 and all inputs SHALL be ignored.
REQ-023 Reset asserted mid-frame or with the FIFO full SHALL discard all content, with no frame_done_o pulse.

Verification
REQ-024 Basic flow: 4x2 frame, out_yumi_i=1, drop_mode_i=0 -> 8 entries out in order, out_data_o for pixel (3,1) equal to {16'd4,16'd2,16'd3,16'd1,24'hRRGGBB}, one frame_done_o pulse, frame_err_o=0.
REQ-025 Backpressure: DEPTH_P=4, out_yumi_i=0, 6 beats offered -> level_o=4, in_accept_o=0 after the 4th write; releasing yumi drains 4 entries, then the remaining 2 are accepted, none lost.
REQ-026 Drop mode: FIFO full, drop_mode_i=1, 3 more beats -> drop_cnt_o=3, level_o=4, stored data unchanged; a concurrent yumi+write at full -> level_o=3, drop_cnt_o=4.
REQ-027 Frame mismatch: 4x2 frame with pixel (1,0) omitted -> frame_done_o pulses, frame_err_o=1 and stays 1 across the next correct frame.
REQ-028 Reset mid-operation: level_o=3 and frame counter=5, then rst_i for 1 cycle -> out_v_o=0, level_o=0, drop_cnt_o=0; the next full 4x2 frame gives frame_done_o with frame_err_o=0.
REQ-029 Wrap: DEPTH_P=4, 20 beats with random yumi -> output order equals input order, level_o never exceeds 4.
